// File: rtl/vram_write_arbiter_if.sv
// Client and VRAM-side signal bundle for the VRAM write arbiter.
// The master modport is the driving environment; the slave modport is the arbiter.
interface vram_write_arbiter_if #(
  parameter int N_REQ  = 8,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 640
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    stall;
  logic                    clear_start;
  logic                    clear_busy;
  logic [DATA_W-1:0]       to_vram_write;
  logic [ADDR_W-1:0]       to_vram_addr;
  logic                    to_vram_wea;

  modport master (
    output req, req_addr, req_data, stall, clear_start,
    input  ack, clear_busy, to_vram_write, to_vram_addr, to_vram_wea
  );

  modport slave (
    input  req, req_addr, req_data, stall, clear_start,
    output ack, clear_busy, to_vram_write, to_vram_addr, to_vram_wea
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing one VRAM row-write port among N_REQ clients,
// with a built-in engine that zero-fills rows 0..ROWS-1 on command.
module vram_write_arbiter #(
  parameter int N_REQ  = 8,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 640,
  parameter int ROWS   = 480
) (
  input logic            clk,
  input logic            rst,
  vram_write_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDX_W + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  ptr;
  logic [ADDR_W-1:0] clear_cnt;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant;
  logic              clear_issue;
  logic              clear_last;
  logic [CW-1:0]     cand;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  assign clear_last = (clear_cnt == ADDR_W'(ROWS - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clear_start) state_next = CLEAR;
      CLEAR:   if (!bus.stall && clear_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Search starts at ptr and wraps; a clear request in IDLE suppresses any grant.
  always_comb begin
    grant       = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    bus.ack     = '0;
    clear_issue = (state == CLEAR) && !bus.stall;
    bus.clear_busy = (state == CLEAR);
    if (rst && state == IDLE && !bus.stall && !bus.clear_start) begin
      for (int i = 0; i < N_REQ; i++) begin
        cand = {1'b0, ptr} + CW'(i);
        if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
        if (!grant && bus.req[cand[IDX_W-1:0]]) begin
          grant     = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
      if (grant) bus.ack[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.to_vram_wea   <= 1'b0;
      bus.to_vram_addr  <= '0;
      bus.to_vram_write <= '0;
      ptr               <= '0;
      clear_cnt         <= '0;
    end else if (grant) begin
      bus.to_vram_wea   <= 1'b1;
      bus.to_vram_addr  <= bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      bus.to_vram_write <= bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
      ptr               <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (clear_issue) begin
      bus.to_vram_wea   <= 1'b1;
      bus.to_vram_addr  <= clear_cnt;
      bus.to_vram_write <= '0;
      clear_cnt         <= clear_cnt + 1'b1;
    end else begin
      bus.to_vram_wea <= 1'b0;
      if (state == IDLE && bus.clear_start) clear_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Self-checking bench for vram_write_arbiter: vector table for arbitration,
// hand sequences for the clear engine, scoreboard queue for registered writes.
module tb_vram_write_arbiter;

  localparam int N_REQ  = 8;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 640;
  localparam int ROWS   = 480;

  typedef struct {
    logic              wea;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic             rst_v;
    logic [N_REQ-1:0] req_v;
    logic [5:0]       tag;
    logic             stall_v;
    logic             clr;
    logic [N_REQ-1:0] exp_ack;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t scb[$];
  vec_t vecs[$];
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  vram_write_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_write_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROWS(ROWS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] client_data(int i, logic [5:0] tag);
    logic [31:0]       w;
    logic [DATA_W-1:0] d;
    w = {8'hA5, 2'b00, tag, 8'(i), 8'h3C};
    d = '0;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = w ^ 32'(k);
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] client_addr(int i, logic [5:0] tag);
    return ADDR_W'(int'(tag) * 8 + i);
  endfunction

  task automatic cmp(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (scb.size() > 0) begin
      e = scb.pop_front();
      cmp("to_vram_wea", DATA_W'(bus.to_vram_wea), DATA_W'(e.wea));
      cmp("to_vram_addr", DATA_W'(bus.to_vram_addr), DATA_W'(e.addr));
      cmp("to_vram_write", bus.to_vram_write, e.data);
    end
  endtask

  // One clock of stimulus: check last cycle's write, drive, check ack/busy, predict next write.
  task automatic apply_stimulus(input logic r, input logic [N_REQ-1:0] rq, input logic [5:0] tag,
                                input logic st, input logic clr, input logic [N_REQ-1:0] exp_ack,
                                input logic exp_busy, input int exp_row);
    exp_t e;
    int   w;
    @(negedge clk);
    check_output();
    rst             = r;
    bus.req         = rq;
    bus.stall       = st;
    bus.clear_start = clr;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = client_addr(i, tag);
      bus.req_data[i*DATA_W +: DATA_W] = client_data(i, tag);
    end
    #1;
    cmp("ack", DATA_W'(bus.ack), DATA_W'(exp_ack));
    cmp("clear_busy", DATA_W'(bus.clear_busy), DATA_W'(exp_busy));
    w = -1;
    for (int i = 0; i < N_REQ; i++) if (exp_ack[i]) w = i;
    if (!r) begin
      last_addr = '0;
      last_data = '0;
      e = '{1'b0, '0, '0};
    end else if (w >= 0) begin
      last_addr = client_addr(w, tag);
      last_data = client_data(w, tag);
      e = '{1'b1, last_addr, last_data};
    end else if (exp_row >= 0) begin
      last_addr = ADDR_W'(exp_row);
      last_data = '0;
      e = '{1'b1, last_addr, last_data};
    end else begin
      e = '{1'b0, last_addr, last_data};
    end
    scb.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_addr = '0;
    last_data = '0;
    rst = 1'b0;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.stall = 1'b0;
    bus.clear_start = 1'b0;

    // reset held with all clients requesting
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 8'hFF, 6'd0, 1'b0, 1'b0, 8'h00});
    // full round robin, ptr starts at 0
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 8'hFF, 6'd0, 1'b0, 1'b0, 8'(1 << i)});
    vecs.push_back('{1'b1, 8'hFF, 6'd0, 1'b0, 1'b0, 8'h01});
    // move ptr to 3, then sparse clients 2 and 5 with fresh data each cycle
    vecs.push_back('{1'b1, 8'h04, 6'd1, 1'b0, 1'b0, 8'h04});
    vecs.push_back('{1'b1, 8'h24, 6'd2, 1'b0, 1'b0, 8'h20});
    vecs.push_back('{1'b1, 8'h24, 6'd3, 1'b0, 1'b0, 8'h04});
    vecs.push_back('{1'b1, 8'h24, 6'd4, 1'b0, 1'b0, 8'h20});
    // stall blocks client 0, grant on first free cycle
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 8'h01, 6'd5, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'h01, 6'd5, 1'b0, 1'b0, 8'h01});
    vecs.push_back('{1'b1, 8'h00, 6'd5, 1'b0, 1'b0, 8'h00});
    // lone client granted back to back, new data after each ack
    vecs.push_back('{1'b1, 8'h02, 6'd9, 1'b0, 1'b0, 8'h02});
    vecs.push_back('{1'b1, 8'h02, 6'd10, 1'b0, 1'b0, 8'h02});
    vecs.push_back('{1'b1, 8'h00, 6'd10, 1'b0, 1'b0, 8'h00});

    foreach (vecs[k])
      apply_stimulus(vecs[k].rst_v, vecs[k].req_v, vecs[k].tag, vecs[k].stall_v,
                     vecs[k].clr, vecs[k].exp_ack, 1'b0, -1);

    // clear with client 4 pending; stall at row 100; stray clear_start at row 50
    apply_stimulus(1'b1, 8'h10, 6'd7, 1'b0, 1'b1, 8'h00, 1'b0, -1);
    for (int r = 0; r < ROWS; r++) begin
      if (r == 100) begin
        apply_stimulus(1'b1, 8'h10, 6'd7, 1'b1, 1'b0, 8'h00, 1'b1, -1);
        apply_stimulus(1'b1, 8'h10, 6'd7, 1'b1, 1'b0, 8'h00, 1'b1, -1);
      end
      apply_stimulus(1'b1, 8'h10, 6'd7, 1'b0, (r == 50), 8'h00, 1'b1, r);
    end
    apply_stimulus(1'b1, 8'h10, 6'd7, 1'b0, 1'b0, 8'h10, 1'b0, -1);
    apply_stimulus(1'b1, 8'h00, 6'd7, 1'b0, 1'b0, 8'h00, 1'b0, -1);

    // reset at row 200 aborts the sweep; a new clear starts over at row 0
    apply_stimulus(1'b1, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00, 1'b0, -1);
    for (int r = 0; r < 200; r++) apply_stimulus(1'b1, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b1, r);
    apply_stimulus(1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    apply_stimulus(1'b1, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b0, -1);
    apply_stimulus(1'b1, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00, 1'b0, -1);
    for (int r = 0; r < 5; r++) apply_stimulus(1'b1, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b1, r);
    apply_stimulus(1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    apply_stimulus(1'b1, 8'h01, 6'd11, 1'b0, 1'b0, 8'h01, 1'b0, -1);

    @(negedge clk);
    check_output();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Shares the single VRAM write port among N_REQ row-writing clients using a valid/ack handshake and rotating-priority (round-robin) arbitration.
- Includes a built-in clear engine that zero-fills every framebuffer row on command.
- Sits between the drawing modules and the VRAM write port (one DATA_W-bit row per address). Issues at most one row write per clock.

Parameters:
N_REQ, 8, number of requesting clients (index width is clog2(N_REQ))
ADDR_W, 9, VRAM row address width
DATA_W, 640, VRAM row width in bits (one pixel per bit)
ROWS, 480, number of rows swept by the clear engine

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0)
req  input  N_REQ  per-client write request; held with addr/data until acked
req_addr  input  N_REQ*ADDR_W  client i row address at bits [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  client i row data at bits [i*DATA_W +: DATA_W]
ack  output  N_REQ  one-hot grant; request accepted at this clock edge
stall  input  1  VRAM write port unavailable this cycle; blocks all issue
clear_start  input  1  pulse: begin zero-fill of rows 0..ROWS-1
clear_busy  output  1  high while the clear engine owns the port
to_vram_write  output  DATA_W  registered row data to VRAM
to_vram_addr  output  ADDR_W  registered row address to VRAM
to_vram_wea  output  1  registered write enable to VRAM

Behaviour:
- Reset (rst==0 at posedge):
  - to_vram_wea=0, to_vram_addr=0, to_vram_write=0.
  - Priority pointer ptr=0, state=IDLE, clear counter=0, clear_busy=0.
  - Reset mid-clear aborts the sweep. Unwritten rows stay as they were.
- ack is combinational from req, ptr, state and stall.
  - At most one bit of ack is high.
  - ack is 0 whenever stall=1, state=CLEAR, or rst=0.
- Arbitration in IDLE with stall=0:
  - Winner w is the first i with req[i]=1, searching ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 (wraps).
  - ack[w]=1 that cycle.
  - At the posedge: to_vram_addr/to_vram_write are loaded from client w, to_vram_wea<=1, ptr<=(w+1) mod N_REQ.
- Latency:
  - The write appears on the to_vram_* outputs the cycle after ack. VRAM commits it on the following edge.
  - Sustained throughput is 1 write/cycle. A lone continuously requesting client is granted every cycle.
- No grant (no req, or stall=1, or clear active on a stalled cycle):
  - to_vram_wea<=0. Addr/data registers hold their previous values.
  - ptr is unchanged.
- Client rules:
  - A client keeps req/addr/data stable until it samples ack=1.
  - A client may present new data with req still high in the cycle after ack.
  - The arbiter has no queueing. Un-acked requests just wait.
- State machine:
  - IDLE -> CLEAR on clear_start=1. clear counter<=0, clear_busy<=1 at that edge.
  - A clear_start that coincides with a pending req takes priority: no ack in that cycle.
  - In CLEAR, each cycle with stall=0 registers to_vram_addr<=counter, to_vram_write<=0, to_vram_wea<=1, and counter<=counter+1.
  - In CLEAR, a cycle with stall=1 gives to_vram_wea<=0 and the counter holds.
  - When the write of row ROWS-1 is issued: state<=IDLE, clear_busy<=0. Arbitration resumes on the next cycle.
  - clear_start while in CLEAR is ignored; the sweep does not restart.
- Width rules:
  - The clear counter is ADDR_W bits. ROWS must be ≤ 2^ADDR_W.
  - ptr arithmetic wraps mod N_REQ; no out-of-range index is ever produced.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with req=8'hFF -> ack=0, to_vram_wea=0, to_vram_addr=0 throughout. After release, the first ack is 8'h01.
2. Round-robin: req=8'hFF held, each client's addr=i, stall=0 -> ack sequence 01,02,04,...,80,01. to_vram_addr lags by one cycle: 0,1,...,7,0, with to_vram_wea=1 continuously.
3. Sparse fairness: req=8'h24 (clients 2,5), ptr=3 -> ack[5] first, then ack[2], then ack[5]. The write data follows the matching req_data slice exactly.
4. Stall: req=8'h01, stall=1 for 4 cycles -> ack=0 and to_vram_wea=0 during the stall. Ack fires the first cycle stall=0, with to_vram_wea=1 one cycle later.
5. Clear:
   - Stimulus: pulse clear_start with req=8'h10 pending; stall=1 for 2 cycles at row 100.
   - Required: exactly 480 writes of zero data at addresses 0..479, in order, with no gaps other than the stalled cycles. clear_busy stays high throughout.
   - Required: ack[4] first appears the cycle after clear_busy falls.
6. Reset mid-clear: drive rst=0 at row 200 -> next cycle clear_busy=0 and to_vram_wea=0. After release, a fresh clear_start restarts the sweep at row 0.
